// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths and the long-latency FIFO entry type for the register-file write controller
package rf_wb_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [REG_AW-1:0] rdc;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_ctrl_if.sv
// rf_wb_ctrl_if: bundle of pipeline writeback, long-latency result, issue, decode query and
// register-file write signals; ctrl modport is the controller side, src modport the environment side
interface rf_wb_ctrl_if #(parameter int CNT_W = 3);
  import rf_wb_pkg::*;
  logic wb_valid;
  logic [REG_AW-1:0] wb_rdc;
  logic [DATA_W-1:0] wb_data;
  logic lu_valid;
  logic lu_ready;
  logic [REG_AW-1:0] lu_rdc;
  logic [DATA_W-1:0] lu_data;
  logic iss_valid;
  logic [REG_AW-1:0] iss_rdc;
  logic [REG_AW-1:0] rsc;
  logic [REG_AW-1:0] rtc;
  logic rs_busy;
  logic rt_busy;
  logic RF_w;
  logic [REG_AW-1:0] rdc;
  logic [DATA_W-1:0] rd;
  logic [CNT_W-1:0] fifo_count;
  logic conflict;
  modport ctrl (
    input wb_valid, wb_rdc, wb_data, lu_valid, lu_rdc, lu_data, iss_valid, iss_rdc, rsc, rtc,
    output lu_ready, rs_busy, rt_busy, RF_w, rdc, rd, fifo_count, conflict
  );
  modport src (
    output wb_valid, wb_rdc, wb_data, lu_valid, lu_rdc, lu_data, iss_valid, iss_rdc, rsc, rtc,
    input lu_ready, rs_busy, rt_busy, RF_w, rdc, rd, fifo_count, conflict
  );
endinterface

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: synchronous FIFO of wb_entry_t; ports clk, rst_n (async low), push/din, pop/dout, full, empty, count
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic full,
  output logic empty,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + CNT_W'(wr) - CNT_W'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: merges pipeline writebacks and FIFO-buffered long-latency results onto the single
// register-file write port (RF_w/rdc/rd) and keeps a per-register pending scoreboard for decode.
// Ports: clk, rst_n (async active-low), bus (rf_wb_ctrl_if.ctrl). Optional macro RF_WB_BYPASS_EN lets an
// accepted result go straight to the output registers when the FIFO is empty and the pipeline is idle.
module rf_wb_ctrl
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst_n,
  rf_wb_ctrl_if.ctrl bus
);
  logic [NUM_REGS-1:0] pending, pending_nxt;
  logic rf_w, src_lu, conflict, full, empty;
  logic [REG_AW-1:0] rdc_q;
  logic [DATA_W-1:0] rd_q;
  logic [CNT_W-1:0] count;
  logic wb_w, lu_ok, byp, push, pop;
  wb_entry_t head;
  assign wb_w = bus.wb_valid && bus.wb_rdc != '0;
  assign lu_ok = bus.lu_valid && !full && bus.lu_rdc != '0;
`ifdef RF_WB_BYPASS_EN
  assign byp = lu_ok && empty && !wb_w;
`else
  assign byp = 1'b0;
`endif
  assign push = lu_ok && !byp;
  assign pop = !wb_w && !empty;
  rf_wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din('{rdc: bus.lu_rdc, data: bus.lu_data}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // A long-latency write clears its busy bit one posedge after RF_w, once the negedge write has landed;
  // a same-cycle issue to that register re-arms it.
  always_comb begin
    pending_nxt = pending;
    if (rf_w && src_lu) pending_nxt[rdc_q] = 1'b0;
    if (bus.iss_valid && bus.iss_rdc != '0) pending_nxt[bus.iss_rdc] = 1'b1;
    pending_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf_w <= 1'b0;
      src_lu <= 1'b0;
      rdc_q <= '0;
      rd_q <= '0;
      pending <= '0;
      conflict <= 1'b0;
    end else begin
      pending <= pending_nxt;
      conflict <= conflict || (wb_w && pending[bus.wb_rdc]);
      rf_w <= wb_w || pop || byp;
      src_lu <= !wb_w && (pop || byp);
      rdc_q <= wb_w ? bus.wb_rdc : pop ? head.rdc : byp ? bus.lu_rdc : rdc_q;
      rd_q <= wb_w ? bus.wb_data : pop ? head.data : byp ? bus.lu_data : rd_q;
    end
  assign bus.lu_ready = !full;
  assign bus.rs_busy = pending[bus.rsc];
  assign bus.rt_busy = pending[bus.rtc];
  assign bus.RF_w = rf_w;
  assign bus.rdc = rdc_q;
  assign bus.rd = rd_q;
  assign bus.fifo_count = count;
  assign bus.conflict = conflict;
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: directed stimulus with an expected-write queue drained by a negedge write monitor
module tb_rf_wb_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [36:0] exp_q[$];
  rf_wb_ctrl_if #(.CNT_W(3)) bus();
  rf_wb_ctrl #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    bus.wb_valid = en;
    bus.wb_rdc = r;
    bus.wb_data = d;
    if (en && r != 5'd0) exp_q.push_back({r, d});
  endtask
  task automatic lu(input logic en, input logic [4:0] r, input logic [31:0] d);
    bus.lu_valid = en;
    bus.lu_rdc = r;
    bus.lu_data = d;
  endtask
  task automatic expect_w(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask
  task automatic iss(input logic en, input logic [4:0] r);
    bus.iss_valid = en;
    bus.iss_rdc = r;
  endtask
  always @(negedge clk)
    if (rst_n && bus.RF_w) begin
      if (exp_q.size() == 0) chk("unexpected_write", {27'd0, bus.rdc}, 32'hFFFF_FFFF);
      else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("write_rdc", {27'd0, bus.rdc}, {27'd0, e[36:32]});
        chk("write_rd", bus.rd, e[31:0]);
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    wb(0, 0, 0);
    lu(0, 0, 0);
    iss(0, 0);
    bus.rsc = 5'd0;
    bus.rtc = 5'd0;
    step();
    step();
    chk("rst_RF_w", bus.RF_w, 0);
    chk("rst_rdc", bus.rdc, 0);
    chk("rst_rd", bus.rd, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_conflict", bus.conflict, 0);
    rst_n = 1'b1;
    step();
    chk("rel_lu_ready", bus.lu_ready, 1);
    chk("rel_RF_w", bus.RF_w, 0);
    // basic pipeline write
    wb(1, 5'd5, 32'h1234);
    step();
    chk("wb_RF_w", bus.RF_w, 1);
    chk("wb_rdc", bus.rdc, 5);
    chk("wb_rd", bus.rd, 32'h1234);
    wb(0, 0, 0);
    step();
    chk("idle_RF_w", bus.RF_w, 0);
    chk("hold_rdc", bus.rdc, 5);
    chk("hold_rd", bus.rd, 32'h1234);
    // long-latency result held behind pipeline writes
    iss(1, 5'd8);
    bus.rsc = 5'd8;
    bus.rtc = 5'd8;
    step();
    iss(0, 0);
    chk("iss_rs_busy", bus.rs_busy, 1);
    chk("iss_rt_busy", bus.rt_busy, 1);
    for (int i = 0; i < 3; i++) begin
      wb(1, 5'(i + 1), 32'hA1 + i);
      lu(i == 0, 5'd8, 32'hDEAD);
      step();
      chk("held_count", bus.fifo_count, 1);
      chk("held_rs_busy", bus.rs_busy, 1);
    end
    lu(0, 0, 0);
    wb(0, 0, 0);
    expect_w(5'd8, 32'hDEAD);
    step();
    chk("drain_RF_w", bus.RF_w, 1);
    chk("drain_rdc", bus.rdc, 8);
    chk("drain_count", bus.fifo_count, 0);
    chk("drain_busy_still", bus.rs_busy, 1);
    step();
    chk("post_RF_w", bus.RF_w, 0);
    chk("cleared_rs_busy", bus.rs_busy, 0);
    // two fill/drain rounds; the first holds a fifth offer until space opens
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 4; i++) begin
        wb(1, 5'd20, 32'h2000 + i);
        lu(1, 5'(10 + 6 * round + i), 32'h1000 * (round + 1) + i);
        step();
      end
      chk("full_count", bus.fifo_count, 4);
      chk("full_lu_ready", bus.lu_ready, 0);
      wb(0, 0, 0);
      for (int i = 0; i < 4; i++) expect_w(5'(10 + 6 * round + i), 32'h1000 * (round + 1) + i);
      if (round == 0) begin
        lu(1, 5'd14, 32'h14);
        expect_w(5'd14, 32'h14);
      end else lu(0, 0, 0);
      for (int i = 0; i < (round == 0 ? 5 : 4); i++) begin
        step();
        if (round == 0 && i == 1) lu(0, 0, 0);
        chk("fill_drain_RF_w", bus.RF_w, 1);
        chk("fill_drain_count", bus.fifo_count, round == 0 ? (i == 0 ? 3 : 4 - i) : 3 - i);
      end
      step();
      chk("fill_idle_RF_w", bus.RF_w, 0);
    end
    // issue to r3 in the very cycle r3's pending bit would clear
    iss(1, 5'd3);
    bus.rsc = 5'd3;
    step();
    iss(0, 0);
    wb(1, 5'd21, 32'h2100);
    lu(1, 5'd3, 32'h33);
    step();
    wb(0, 0, 0);
    lu(0, 0, 0);
    expect_w(5'd3, 32'h33);
    step();
    chk("r3_RF_w", bus.RF_w, 1);
    chk("r3_rdc", bus.rdc, 3);
    iss(1, 5'd3);
    step();
    iss(0, 0);
    chk("set_wins_busy", bus.rs_busy, 1);
    step();
    chk("set_wins_stays", bus.rs_busy, 1);
    // r0 results and issues are discarded
    lu(1, 5'd0, 32'h77);
    iss(1, 5'd0);
    bus.rsc = 5'd0;
    step();
    lu(0, 0, 0);
    iss(0, 0);
    chk("r0_RF_w", bus.RF_w, 0);
    chk("r0_count", bus.fifo_count, 0);
    chk("r0_busy", bus.rs_busy, 0);
    step();
    chk("r0_RF_w_late", bus.RF_w, 0);
    // pipeline write to r0 leaves the port free for a drain
    wb(1, 5'd20, 32'h3000);
    lu(1, 5'd6, 32'h66);
    step();
    lu(0, 0, 0);
    wb(1, 5'd0, 32'h0BAD);
    expect_w(5'd6, 32'h66);
    step();
    chk("wb0_drain_RF_w", bus.RF_w, 1);
    chk("wb0_drain_rdc", bus.rdc, 6);
    wb(0, 0, 0);
    step();
    // pipeline write to a pending register
    iss(1, 5'd9);
    bus.rsc = 5'd9;
    step();
    iss(0, 0);
    chk("pre_conflict", bus.conflict, 0);
    wb(1, 5'd9, 32'h99);
    step();
    chk("conflict_set", bus.conflict, 1);
    chk("conflict_busy", bus.rs_busy, 1);
    wb(1, 5'd20, 32'h3100);
    lu(1, 5'd9, 32'h999);
    step();
    wb(0, 0, 0);
    lu(0, 0, 0);
    expect_w(5'd9, 32'h999);
    step();
    chk("r9_lu_rdc", bus.rdc, 9);
    step();
    chk("r9_busy_clear", bus.rs_busy, 0);
    chk("conflict_sticky", bus.conflict, 1);
    // reset with two queued entries
    wb(1, 5'd20, 32'h3200);
    lu(1, 5'd11, 32'hB1);
    step();
    wb(1, 5'd20, 32'h3201);
    lu(1, 5'd12, 32'hB2);
    step();
    chk("preq_count", bus.fifo_count, 2);
    wb(0, 0, 0);
    lu(0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_count", bus.fifo_count, 0);
    chk("mid_rst_RF_w", bus.RF_w, 0);
    chk("mid_rst_conflict", bus.conflict, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("after_rst_RF_w", bus.RF_w, 0);
    end
    chk("after_rst_lu_ready", bus.lu_ready, 1);
    // idle controller, single long-latency result
    iss(1, 5'd4);
    bus.rsc = 5'd4;
    step();
    iss(0, 0);
    lu(1, 5'd4, 32'h55);
    expect_w(5'd4, 32'h55);
    step();
    lu(0, 0, 0);
`ifdef RF_WB_BYPASS_EN
    chk("byp_RF_w", bus.RF_w, 1);
    chk("byp_rdc", bus.rdc, 4);
    chk("byp_count", bus.fifo_count, 0);
    step();
    chk("byp_next_RF_w", bus.RF_w, 0);
    chk("byp_busy_clear", bus.rs_busy, 0);
`else
    chk("nobyp_RF_w", bus.RF_w, 0);
    chk("nobyp_count", bus.fifo_count, 1);
    step();
    chk("nobyp_late_RF_w", bus.RF_w, 1);
    chk("nobyp_rdc", bus.rdc, 4);
    chk("nobyp_busy", bus.rs_busy, 1);
    step();
    chk("nobyp_busy_clear", bus.rs_busy, 0);
`endif
    step();
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
- Write-side controller for the 32x32 register file. It merges single-cycle pipeline writeback results with results from long-latency units (mult/div, HI/LO moves, cache-miss loads) into the file's single write port (RF_w/rdc/rd).
- Long-latency results are buffered in a small FIFO and drained on cycles the pipeline does not write.
- A per-register pending scoreboard tells the decode stage whether rs/rt still await a long-latency result, so decode can stall.

Parameters:
- DEPTH, 4, long-latency result FIFO entries (power of 2, 2..16)
- CNT_W, $clog2(DEPTH)+1, width of fifo_count

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  pipeline writeback request; always accepted, highest priority
- wb_rdc  in  5  pipeline destination register
- wb_data  in  32  pipeline result
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  FIFO can accept (count < DEPTH)
- lu_rdc  in  5  long-latency destination register
- lu_data  in  32  long-latency result
- iss_valid  in  1  long-latency op dispatched this cycle
- iss_rdc  in  5  its destination register
- rsc  in  5  decode source register A query
- rtc  in  5  decode source register B query
- rs_busy  out  1  pending[rsc]
- rt_busy  out  1  pending[rtc]
- RF_w  out  1  register file write enable
- rdc  out  5  register file write address
- rd  out  32  register file write data
- fifo_count  out  CNT_W  current FIFO occupancy
- conflict  out  1  sticky: pipeline wrote a register that was pending

Behaviour:
- Reset (async, rst_n=0):
  - RF_w=0, rdc=0, rd=0, fifo_count=0, conflict=0, pending all 0.
  - FIFO flushed; lu_ready=1 once reset is released.
  - Reset mid-drain discards all queued entries; nothing is written.
- Output registers: RF_w/rdc/rd load every posedge. The register file samples them on the following negedge, so write latency is half a cycle after the output registers load.
- Per-posedge priority:
  1. wb_valid && wb_rdc!=0 -> load wb_rdc/wb_data, RF_w=1.
  2. Otherwise, if FIFO not empty -> pop head into outputs, RF_w=1.
  3. Otherwise RF_w=0; rdc/rd hold their previous values.
- wb_valid with wb_rdc==0 -> treated as no pipeline write; the FIFO may drain that cycle.
- Enqueue: lu_valid && lu_ready && lu_rdc!=0 -> push.
  - lu_rdc==0 is consumed (handshake completes) but discarded.
  - Push and pop in the same cycle are allowed: count is unchanged. When full, lu_ready is computed from the pre-pop count, so there is no same-cycle pass-through.
  - lu_valid while !lu_ready: the source holds its data; no loss, no duplicate.
- Ordering: FIFO drains strictly FIFO. Two queued writes to the same register retire in arrival order, so the last one wins.
- Scoreboard:
  - Set: iss_valid && iss_rdc!=0 sets pending[iss_rdc] at posedge.
  - Clear: pending[r] clears at the posedge after the cycle in which RF_w=1 with rdc=r from a FIFO pop. The busy flag therefore stays high until the negedge write is visible.
  - Set and clear of the same register in the same cycle: set wins.
  - pending[0] is constantly 0.
  - rs_busy/rt_busy are combinational lookups.
- Conflict: conflict sets when a pipeline write targets r with pending[r]=1. It stays set until reset. The pipeline write still proceeds, and the later FIFO write to r still lands.
- Count arithmetic is unsigned; count never exceeds DEPTH or underflows (pop only when count>0).

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined: when the FIFO is empty and there is no pipeline write, an accepted lu result loads the output registers directly at the same posedge (1-cycle latency) without being enqueued. fifo_count stays 0.
- Undefined: every lu result passes through the FIFO; minimum latency is 2 posedges from acceptance to RF_w=1.
- Scoreboard clear timing is relative to the RF_w cycle in both builds.

Decomposition:
- Package rf_wb_pkg: REG_AW=5, DATA_W=32, NUM_REGS=32, and a typedef for the FIFO entry {rdc[4:0], data[31:0]}.
- Sub-module rf_wb_fifo: parameterised synchronous FIFO with push/pop/full/empty/count. Its pointers wrap modulo DEPTH.
- Arbitration, output registers and scoreboard live in the top module.

Test Plan:
- Reset, then wb_valid=1, wb_rdc=5, wb_data=0x1234 -> after the next posedge RF_w=1, rdc=5, rd=0x1234. The following cycle has RF_w=0.
- iss r8, then lu r8=0xDEAD while wb_valid is held high for 3 cycles -> fifo_count=1 and rs_busy(rsc=8)=1 throughout. The drain occurs on the first wb-idle cycle. rs_busy drops one posedge after RF_w with rdc=8.
- Push 4 lu results with wb_valid continuously 1 (DEPTH=4) -> lu_ready=0 at count 4. Release wb -> 4 consecutive writes in order, with pointer wrap exercised across two fill/drain rounds.
- iss_valid to r3 in the same cycle r3's pending bit clears -> pending[3] remains 1. lu write and iss to r0 -> no RF_w and no busy.
- wb write to pending r9 -> conflict=1 sticky. Then assert rst_n=0 with 2 entries queued -> count=0, RF_w=0, conflict=0, no further writes.
- With RF_WB_BYPASS_EN, lu r4=0x55 into an empty idle controller -> RF_w=1 after the same posedge, fifo_count stays 0. Without the macro, RF_w=1 one posedge later.
